wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports are as below.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- wb_we  in  1  pipeline WB stage write request
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- aux_valid  in  1  auxiliary (multi-cycle MDU) result valid
- aux_ready  out  1  arbiter can accept aux result
- aux_addr  in  5  aux destination register
- aux_data  in  32  aux write data
- stall_req  out  1  pipeline must hold WB stage this cycle
- rf_we  out  1  register-file write enable
- rf_addr  out  5  register-file write address
- rf_data  out  32  register-file write data
- pending  out  1  aux buffer non-empty

Function
REQ-002 The block SHALL share the single register-file write port between WB (primary) and aux (secondary) through a 2-entry aux FIFO.
REQ-003 An aux result SHALL be accepted on a cycle with aux_valid=1 and aux_ready=1; aux_ready = FIFO not full, from registered occupancy only (no same-cycle pass-through when full).
REQ-004 An accepted aux result SHALL reach rf outputs no earlier than the next cycle (minimum latency 1).
REQ-005 An aux request with aux_addr=0 SHALL be accepted and discarded, never stored.
REQ-006 rf_we SHALL never be 1 with rf_addr=0; WB writes with wb_addr=0 count as WB idle.
REQ-007 FSM states: IDLE (FIFO empty), WAIT (non-empty, WB has priority), DRAIN (stall_req=1).
REQ-008 IDLE/WAIT: if wb_we=1 and wb_addr!=0, rf outputs = WB; else if FIFO non-empty, rf outputs = head and head pops; else rf_we=0.
REQ-009 In WAIT a 2-bit starve counter SHALL increment each cycle the head is not written, clear on every head pop, and on reaching 3 move the FSM to DRAIN next cycle.
REQ-010 DRAIN: stall_req=1 (combinational from state), head written, WB inputs ignored (pipeline replays them); next state WAIT with counter 0 if entries remain, else IDLE.
REQ-011 Kill rule: in IDLE/WAIT, a WB write to address A SHALL invalidate every FIFO entry with addr A the same cycle (younger write wins); invalidated entries are removed without writing and free space that cycle.
REQ-012 Simultaneous accept and pop (or kill) SHALL keep occupancy consistent; pointers wrap modulo 2.
REQ-013 pending = occupancy != 0; stall_req=0 outside DRAIN.

Reset
REQ-014 rst_n=0 at a clock edge SHALL empty the FIFO, clear the counter and enter IDLE, discarding any in-flight entry, including mid-DRAIN.
REQ-015 During and after reset: rf_we=0, stall_req=0, pending=0, aux_ready=1 (accepting from the first cycle with rst_n=1), rf_addr=0, rf_data=0.

Structure
REQ-016 Shared package cpu_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, AUX_FIFO_DEPTH=2, STARVE_LIMIT=3 and the FSM state enum.
REQ-017 FIFO storage plus kill masking SHALL be one sub-module, wb_aux_fifo; arbitration, counter and FSM stay in wb_port_arbiter.

Verification
REQ-018 Idle WB, aux (addr 5, 0x11) accepted cycle 0 -> cycle 1 rf_we=1, rf_addr=5, rf_data=0x11, pending 0 by cycle 2.
REQ-019 wb_we=1 (addr 3) every cycle, aux (addr 7) queued -> 3 WB-won cycles, then DRAIN: stall_req=1 for one cycle, rf_addr=7, WB ignored that cycle.
REQ-020 Two aux accepted, third offered while full -> aux_ready=0 and third not accepted until a pop.
REQ-021 FIFO holds addr 9; WB writes addr 9 -> entry killed, no later write to 9, pending=0.
REQ-022 aux_addr=0 accepted -> rf_we stays 0; rst_n=0 during DRAIN -> next cycle stall_req=0, pending=0, aux_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants, FSM state type and helpers for the register-file write-port arbiter.
package cpu_pkg;
  localparam int REG_ADDR_W     = 5;
  localparam int DATA_W         = 32;
  localparam int AUX_FIFO_DEPTH = 2;
  localparam int STARVE_LIMIT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Register 0 is hardwired, so writes to it are no-ops everywhere.
  function automatic logic is_live_addr(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction
endpackage

// File: rtl/wb_aux_fifo.sv
// Two-entry aux result buffer with same-cycle kill of entries overwritten by a younger WB write.
module wb_aux_fifo
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [REG_ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0]     i_push_data,
  input  logic                  i_pop,
  input  logic                  i_kill,
  input  logic [REG_ADDR_W-1:0] i_kill_addr,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [REG_ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0]     o_head_data,
  output logic [1:0]            o_count_next
);
  logic [AUX_FIFO_DEPTH-1:0] r_vld;
  logic [REG_ADDR_W-1:0]     r_addr [AUX_FIFO_DEPTH];
  logic [DATA_W-1:0]         r_data [AUX_FIFO_DEPTH];
  logic                      r_rd_ptr;

  logic [AUX_FIFO_DEPTH-1:0] w_vld_k;
  logic [AUX_FIFO_DEPTH-1:0] w_vld_next;
  logic                      w_wr_slot;
  logic                      w_rd_ptr_next;
  logic                      w_push_ok;

  // r_rd_ptr always names the oldest valid slot, so the head is simply that slot.
  for (genvar gi = 0; gi < AUX_FIFO_DEPTH; gi++) begin : g_slot
    assign w_vld_k[gi] = r_vld[gi]
                         && !(i_kill && (r_addr[gi] == i_kill_addr))
                         && !(i_pop && (r_rd_ptr == 1'(gi)));
  end

  always_comb begin
    w_wr_slot     = 1'b0;
    w_rd_ptr_next = r_rd_ptr;
    case (w_vld_k)
      2'b01:   begin w_wr_slot = 1'b1; w_rd_ptr_next = 1'b0; end
      2'b10:   begin w_wr_slot = 1'b0; w_rd_ptr_next = 1'b1; end
      2'b00:   begin w_wr_slot = 1'b0; w_rd_ptr_next = 1'b0; end
      default: ;
    endcase
  end

  assign w_push_ok    = i_push && !(&w_vld_k);
  assign w_vld_next   = w_vld_k | (AUX_FIFO_DEPTH'(w_push_ok) << w_wr_slot);
  assign o_count_next = 2'(w_vld_next[0]) + 2'(w_vld_next[1]);
  assign o_full       = &r_vld;
  assign o_empty      = ~|r_vld;
  assign o_head_addr  = r_addr[r_rd_ptr];
  assign o_head_data  = r_data[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_vld    <= w_vld_next;
      r_rd_ptr <= w_rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_addr[w_wr_slot] <= i_push_addr;
      r_data[w_wr_slot] <= i_push_data;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and buffered aux (MDU) results,
// forcing a one-cycle pipeline stall when aux results have been starved too long.
module wb_port_arbiter
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [REG_ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0]     aux_data,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic                  pending
);
  arb_state_e            r_state;
  logic [1:0]            r_starve;

  logic                  w_full;
  logic                  w_empty;
  logic [REG_ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0]     w_head_data;
  logic [1:0]            w_count_next;
  logic                  w_drain;
  logic                  w_wb_act;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_kill;
  logic                  w_rf_we;
  logic [REG_ADDR_W-1:0] w_rf_addr;
  logic [DATA_W-1:0]     w_rf_data;

  assign w_drain  = (r_state == ST_DRAIN);
  assign w_wb_act = wb_we && is_live_addr(wb_addr);
  // Address-0 aux results are acknowledged but never enter the buffer.
  assign w_push   = aux_valid && !w_full && is_live_addr(aux_addr);
  assign w_kill   = !w_drain && w_wb_act;
  assign w_pop    = !w_empty && (w_drain || !w_wb_act);

  wb_aux_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_addr  (aux_addr),
    .i_push_data  (aux_data),
    .i_pop        (w_pop),
    .i_kill       (w_kill),
    .i_kill_addr  (wb_addr),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_count_next (w_count_next)
  );

  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_addr = '0;
    w_rf_data = '0;
    if (w_kill) begin
      w_rf_we   = 1'b1;
      w_rf_addr = wb_addr;
      w_rf_data = wb_data;
    end else if (w_pop) begin
      w_rf_we   = 1'b1;
      w_rf_addr = w_head_addr;
      w_rf_data = w_head_data;
    end
  end

  // Outputs are held quiet while reset is asserted so an in-flight drain never lands.
  assign rf_we     = rst_n && w_rf_we;
  assign rf_addr   = rst_n ? w_rf_addr : '0;
  assign rf_data   = rst_n ? w_rf_data : '0;
  assign stall_req = rst_n && w_drain;
  assign pending   = rst_n && !w_empty;
  assign aux_ready = !rst_n || !w_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
    end else if (w_count_next == 2'd0) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
    end else if ((r_state == ST_WAIT) && w_wb_act) begin
      r_starve <= r_starve + 2'd1;
      r_state  <= (r_starve == 2'(STARVE_LIMIT - 1)) ? ST_DRAIN : ST_WAIT;
    end else begin
      r_state  <= ST_WAIT;
      r_starve <= '0;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter: expected RF writes are queued by the stimulus
// and popped by a negedge monitor; status outputs are checked at fixed points.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        pending;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_addr  (aux_addr),
    .aux_data  (aux_data),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .pending   (pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    wb_we = we; wb_addr = wa; wb_data = wd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RF write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %0h, expected no write", rf_addr, rf_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (rf_addr !== e.addr || rf_data !== e.data) begin
          n_fail++;
          $display("[TB] FAIL rf_write: got addr %0d data %0h, expected addr %0d data %0h",
                   rf_addr, rf_data, e.addr, e.data);
        end else begin
          $display("[TB] ok   rf_write addr %0d data %0h", rf_addr, rf_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rf_we",     32'(rf_we),     0);
    chk("rst_stall",     32'(stall_req), 0);
    chk("rst_pending",   32'(pending),   0);
    chk("rst_aux_ready", 32'(aux_ready), 1);
    chk("rst_rf_addr",   32'(rf_addr),   0);
    chk("rst_rf_data",   rf_data,        0);
    next_cyc();
    rst_n = 1'b1;

    // Idle WB: aux result lands one cycle after acceptance.
    drive(0, 0, 0, 1, 5'd5, 32'h11);
    expect_wr(5'd5, 32'h11);
    @(negedge clk); chk("s1_ready_c0", 32'(aux_ready), 1);
    next_cyc(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("s1_pend_c1", 32'(pending), 1);
    next_cyc();
    @(negedge clk); chk("s1_pend_c2", 32'(pending), 0);
    next_cyc();

    // WB busy every cycle: three WB wins then one DRAIN cycle for the aux entry.
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'd3, 32'hA0 + i, i == 0, 5'd7, 32'h77);
      if (i == 4) expect_wr(5'd7, 32'h77);
      else        expect_wr(5'd3, 32'hA0 + i);
      @(negedge clk); chk($sformatf("s2_stall_c%0d", i), 32'(stall_req), (i == 4) ? 1 : 0);
      next_cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("s2_pend_end", 32'(pending), 0);
    next_cyc();

    // Fill the buffer: third aux result is back-pressured until a slot frees.
    for (int i = 0; i < 7; i++) begin
      logic [4:0] aa;
      aa = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
      drive(i < 5, 5'd3, 32'hB0 + i, i <= 5, aa, 32'h100 + 32'(aa) - 32'd10);
      case (i)
        0, 1, 2, 3: expect_wr(5'd3, 32'hB0 + i);
        4:          expect_wr(5'd10, 32'h100);
        5:          expect_wr(5'd11, 32'h101);
        default:    expect_wr(5'd12, 32'h102);
      endcase
      @(negedge clk);
      if (i <= 5)
        chk($sformatf("s3_ready_c%0d", i), 32'(aux_ready), (i >= 2 && i <= 4) ? 0 : 1);
      next_cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("s3_pend_end", 32'(pending), 0);
    next_cyc();

    // WB write to a buffered address kills the stale aux entry.
    drive(0, 0, 0, 1, 5'd9, 32'h99);
    next_cyc();
    drive(1, 5'd9, 32'h55, 0, 0, 0);
    expect_wr(5'd9, 32'h55);
    @(negedge clk); chk("s4_pend_c1", 32'(pending), 1);
    next_cyc(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("s4_pend_c2", 32'(pending), 0);
    next_cyc();
    @(negedge clk); chk("s4_pend_c3", 32'(pending), 0);
    next_cyc();

    // Address-0 aux is swallowed; address-0 WB counts as idle and lets the head drain.
    drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
    @(negedge clk); chk("s5_ready_r0", 32'(aux_ready), 1);
    next_cyc(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s5_pend_r0", 32'(pending), 0);
    chk("s5_we_r0",   32'(rf_we),   0);
    next_cyc();
    drive(0, 0, 0, 1, 5'd4, 32'h44);
    next_cyc();
    drive(1, 5'd0, 32'hFF, 0, 0, 0);
    expect_wr(5'd4, 32'h44);
    next_cyc(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("s5_pend_end", 32'(pending), 0);
    next_cyc();

    // Reset asserted during DRAIN discards both buffered entries.
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'd3, 32'hC0 + i, i < 2, (i == 0) ? 5'd7 : 5'd8, 32'h70 + i);
      if (i < 4) expect_wr(5'd3, 32'hC0 + i);
      else       rst_n = 1'b0;
      @(negedge clk);
      if (i == 3) chk("s6_stall_c3", 32'(stall_req), 0);
      if (i == 4) chk("s6_stall_rst", 32'(stall_req), 0);
      next_cyc();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s6_stall_after", 32'(stall_req), 0);
    chk("s6_pend_after",  32'(pending),   0);
    chk("s6_ready_after", 32'(aux_ready), 1);
    next_cyc();
    @(negedge clk); chk("s6_pend_later", 32'(pending), 0);
    next_cyc();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
